sprite_loader: RTL and testbench
================================

# sprite_loader

Write-side front end for the sprite storage block. It consumes the byte stream delivered by the SPI receiver, parses a sprite-load frame, and drives the storage write port (`w_select`, `w_en`, `w_addr`, `w_data`), filling one sprite with two 4-bit pixels per byte. It sits between the SPI byte receiver and sprite storage in the SPI driver path, and reports completion and errors to the control logic.

## Interface

**Parameters**
- `SPRITE_NUM`, default 4: number of sprite slots.
- `SPRITE_SIZE`, default 1024: pixels per sprite; must be even.
- `SPRITE_ADDR_SIZE`, default 9: pixel address MSB index; address width is `SPRITE_ADDR_SIZE+1`.

**Ports**
- `clock`, input, 1: system clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `cs_n`, input, 1: SPI chip select, synchronised to `clock`. Low means a frame is active.
- `rx_valid`, input, 1: single-cycle strobe; `rx_data` holds a received byte.
- `rx_data`, input, 8: received byte.
- `w_select`, output, `$clog2(SPRITE_NUM)`: target sprite slot.
- `w_en`, output, 1: storage write strobe.
- `w_addr`, output, `SPRITE_ADDR_SIZE+1`: pixel address of the high nibble.
- `w_data`, output, 8: `[7:4]` is the pixel at `w_addr`; `[3:0]` is the pixel at `w_addr+1`.
- `busy`, output, 1: a frame is being parsed.
- `done`, output, 1: one-cycle pulse when a sprite load completes successfully.
- `err`, output, 2: error code. 0 = none, 1 = bad opcode, 2 = index out of range, 3 = abort or checksum error. Sticky until the next frame start.

## Operation
- **Frame format:** opcode byte `LOAD_OP` = 0x01, then a sprite index byte, then `SPRITE_SIZE/2` data bytes. With the configuration macro defined, a checksum byte follows the data.
- **Register states:** IDLE, CMD, INDEX, DATA, CHECK, HOLD.
- **IDLE:** entered on reset or when `cs_n` is high. A falling `cs_n` moves to CMD and clears `err` to 0.
- **CMD:**
  - Byte equals `LOAD_OP`: go to INDEX.
  - Any other byte: `err` becomes 1 and the FSM goes to HOLD.
- **INDEX:**
  - Byte < `SPRITE_NUM`: latch it into `w_select`, clear the address counter, go to DATA.
  - Otherwise: `err` becomes 2 and the FSM goes to HOLD.
- **DATA:** each byte produces one write at the current counter value, then the counter advances by 2.
  - After the byte written at address `SPRITE_SIZE-2`, go to CHECK (macro defined) or HOLD with `done` (macro undefined).
  - The counter never wraps.
- **HOLD:** all bytes are ignored until `cs_n` goes high, which returns the FSM to IDLE.
- **Chip select:**
  - `cs_n` high in any state returns the FSM to IDLE.
  - If that happens in INDEX, DATA or CHECK, `err` becomes 3.
  - Sprite data already written is left in place.
- **Simultaneous events:** when `rx_valid` and a rising `cs_n` occur in the same cycle, `cs_n` wins and the byte is discarded with no write.
- **Ignored input:** `rx_valid` while in IDLE is ignored.
- **busy:** high in CMD, INDEX, DATA and CHECK.

## Timing
- **Reset values:** `w_en`=0, `w_select`=0, `w_addr`=0, `w_data`=0, `busy`=0, `done`=0, `err`=0. State is IDLE.
- **Write latency:** all outputs are registered. `w_en` pulses for one cycle, in the cycle after the `rx_valid` that carried the data byte. `w_addr` and `w_data` are valid in that same cycle.
- **Back-to-back bytes:** `rx_valid` may assert on consecutive cycles. Each byte produces exactly one write, with no stalls and no backpressure.
- **done:**
  - Without the macro: asserts in the same cycle as the final `w_en`.
  - With the macro: asserts one cycle after the checksum byte's `rx_valid`.
- **err:** updates one cycle after the causing byte or `cs_n` edge.

## Configuration
- **Macro:** `SPRITE_LOADER_CHECKSUM_EN`.
- **Defined:**
  - A running XOR of all data bytes is kept.
  - CHECK expects one byte equal to that XOR.
  - On a match: `done` pulses and the FSM goes to HOLD.
  - On a mismatch: `err` becomes 3, there is no `done`, and the FSM goes to HOLD. Data already written is not rolled back.
- **Undefined:** there is no CHECK state and no XOR register; DATA goes directly to HOLD.

## Structure
- **Package `sprite_pkg`:** holds `SPRITE_NUM`, `SPRITE_SIZE`, `SPRITE_ADDR_SIZE`, `LOAD_OP`, the state enum typedef and the error-code enum. Sprite storage and the SPI driver share it.
- **Sub-modules:** none. The FSM, address counter and XOR accumulator together are small enough to live in one module.

## Test plan
- **Full load, macro off:** `cs_n` low, bytes 0x01, 0x02, then 512 bytes `i[7:0]`.
  - Expect 512 `w_en` pulses with `w_select`=2 and `w_addr`=0,2,…,1022.
  - Expect `w_data` to equal the byte sent, `done` on the last write, and `err`=0.
- **Bad opcode:** first byte 0x7F, then 10 bytes.
  - Expect `err`=1, no `w_en`, and `busy`=0 after one cycle.
- **Bad index:** 0x01, then 0x04 with `SPRITE_NUM`=4.
  - Expect `err`=2 and no writes.
- **Abort:** `cs_n` rises after 100 data bytes.
  - Expect exactly 100 writes, `err`=3 and no `done`.
  - A following frame clears `err` on the `cs_n` fall.
- **Checksum, macro on:** correct XOR byte gives `done` and `err`=0. A wrong byte gives `err`=3, no `done`, and all 512 writes still present.
- **Collision:** a last data byte coinciding with a rising `cs_n` gives no write for that byte and `err`=3.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite storage path: geometry, load opcode,
// loader state and error encodings.
package sprite_pkg;

    localparam int SPRITE_NUM       = 4;
    localparam int SPRITE_SIZE      = 1024;
    localparam int SPRITE_ADDR_SIZE = 9;

    localparam logic [7:0] LOAD_OP = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_INDEX = 3'd2,
        ST_DATA  = 3'd3,
        ST_CHECK = 3'd4,
        ST_HOLD  = 3'd5
    } loader_state_t;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_OPCODE = 2'd1,
        ERR_INDEX  = 2'd2,
        ERR_ABORT  = 2'd3
    } loader_err_t;

    // Running XOR used for the optional frame checksum.
    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/sprite_loader.sv
// Parses SPI sprite-load frames and drives the sprite storage write port.
// Define SPRITE_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module sprite_loader #(
    parameter int SPRITE_NUM       = sprite_pkg::SPRITE_NUM,
    parameter int SPRITE_SIZE      = sprite_pkg::SPRITE_SIZE,
    parameter int SPRITE_ADDR_SIZE = sprite_pkg::SPRITE_ADDR_SIZE
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          cs_n,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    output logic [$clog2(SPRITE_NUM)-1:0] w_select,
    output logic                          w_en,
    output logic [SPRITE_ADDR_SIZE:0]     w_addr,
    output logic [7:0]                    w_data,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    err
);
    import sprite_pkg::*;

    localparam int SW = $clog2(SPRITE_NUM);
    localparam int AW = SPRITE_ADDR_SIZE + 1;
    localparam logic [AW-1:0] ADDR_LAST = AW'(SPRITE_SIZE - 2);
    localparam logic [AW-1:0] ADDR_STEP = AW'(2);

    loader_state_t   state_r;
    loader_err_t     err_r;
    logic            cs_prev_r;
    logic [AW-1:0]   addr_cnt_r;
    logic [SW-1:0]   sel_r;
    logic            w_en_r;
    logic [AW-1:0]   w_addr_r;
    logic [7:0]      w_data_r;
    logic            busy_r;
    logic            done_r;
`ifdef SPRITE_LOADER_CHECKSUM_EN
    logic [7:0]      xor_r;
`endif
    logic            index_ok_s;

    assign index_ok_s = (int'({24'd0, rx_data}) < SPRITE_NUM);

    // Frame FSM; every output is produced here so they all leave a flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            err_r      <= ERR_NONE;
            cs_prev_r  <= 1'b1;
            addr_cnt_r <= '0;
            sel_r      <= '0;
            w_en_r     <= 1'b0;
            w_addr_r   <= '0;
            w_data_r   <= 8'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
            xor_r      <= 8'd0;
`endif
        end else begin
            cs_prev_r <= cs_n;
            w_en_r    <= 1'b0;
            done_r    <= 1'b0;
            // Deselect overrides any byte arriving in the same cycle.
            if (cs_n) begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
                if (state_r inside {ST_INDEX, ST_DATA, ST_CHECK}) begin
                    err_r <= ERR_ABORT;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (cs_prev_r) begin
                            state_r <= ST_CMD;
                            busy_r  <= 1'b1;
                            err_r   <= ERR_NONE;
                        end
                    end
                    ST_CMD: begin
                        if (rx_valid) begin
                            if (rx_data == LOAD_OP) begin
                                state_r <= ST_INDEX;
                            end else begin
                                state_r <= ST_HOLD;
                                busy_r  <= 1'b0;
                                err_r   <= ERR_OPCODE;
                            end
                        end
                    end
                    ST_INDEX: begin
                        if (rx_valid) begin
                            if (index_ok_s) begin
                                sel_r      <= rx_data[SW-1:0];
                                addr_cnt_r <= '0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
                                xor_r      <= 8'd0;
`endif
                                state_r    <= ST_DATA;
                            end else begin
                                state_r <= ST_HOLD;
                                busy_r  <= 1'b0;
                                err_r   <= ERR_INDEX;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (rx_valid) begin
                            w_en_r   <= 1'b1;
                            w_addr_r <= addr_cnt_r;
                            w_data_r <= rx_data;
`ifdef SPRITE_LOADER_CHECKSUM_EN
                            xor_r    <= xor_fold(xor_r, rx_data);
`endif
                            // Counter stops at the last pair rather than wrapping.
                            if (addr_cnt_r == ADDR_LAST) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
                                state_r <= ST_CHECK;
`else
                                state_r <= ST_HOLD;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
`endif
                            end else begin
                                addr_cnt_r <= addr_cnt_r + ADDR_STEP;
                            end
                        end
                    end
`ifdef SPRITE_LOADER_CHECKSUM_EN
                    ST_CHECK: begin
                        if (rx_valid) begin
                            state_r <= ST_HOLD;
                            busy_r  <= 1'b0;
                            if (rx_data == xor_r) begin
                                done_r <= 1'b1;
                            end else begin
                                err_r  <= ERR_ABORT;
                            end
                        end
                    end
`endif
                    ST_HOLD: begin
                        state_r <= ST_HOLD;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign w_select = sel_r;
    assign w_en     = w_en_r;
    assign w_addr   = w_addr_r;
    assign w_data   = w_data_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_sprite_loader.sv
// Self-checking bench for sprite_loader: directed and random frames compared
// against a frame-level reference model of the load protocol.
module tb_sprite_loader;

    typedef logic [7:0] byte_q_t[$];

    localparam int NUM  = 4;
    localparam int HALF = 512;
`ifdef SPRITE_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cs_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [1:0] w_select;
    logic       w_en;
    logic [9:0] w_addr;
    logic [7:0] w_data;
    logic       busy;
    logic       done;
    logic [1:0] err;

    int tests = 0;
    int fails = 0;

    logic [19:0] got_q[$];
    logic [19:0] exp_q[$];
    int          cyc = 0;
    int          done_cnt;
    int          last_wen_cyc;
    int          done_cyc;
    logic [1:0]  exp_err;
    int          exp_done;

    always #5 clock = ~clock;

    sprite_loader dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .cs_n     (cs_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .w_select (w_select),
        .w_en     (w_en),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // Record every storage write and done pulse away from the active edge.
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (w_en) begin
            got_q.push_back({w_select, w_addr, w_data});
            last_wen_cyc = cyc;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rise);
        rx_valid = 1'b1;
        rx_data  = b;
        if (rise) cs_n = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic frame_start();
        got_q.delete();
        done_cnt     = 0;
        last_wen_cyc = -1;
        done_cyc     = -2;
        cs_n = 1'b0;
        tick();
    endtask

    task automatic frame_end(input bit already_high);
        if (!already_high) begin
            cs_n = 1'b1;
            tick();
        end
        tick();
        tick();
    endtask

    // Frame-level reference: what the load protocol says a byte sequence writes.
    task automatic model(input byte_q_t fb, input bit collide);
        int eff;
        int nd;
        logic [7:0] x;
        logic [7:0] idx;
        exp_q.delete();
        exp_err  = 2'd0;
        exp_done = 0;
        eff = collide ? fb.size() - 1 : fb.size();
        if (eff == 0) return;
        if (fb[0] != 8'h01) begin exp_err = 2'd1; return; end
        if (eff == 1) begin exp_err = 2'd3; return; end
        idx = fb[1];
        if (int'(idx) >= NUM) begin exp_err = 2'd2; return; end
        nd = eff - 2;
        if (nd > HALF) nd = HALF;
        x = 8'd0;
        for (int i = 0; i < nd; i++) begin
            exp_q.push_back({idx[1:0], 10'(2 * i), fb[2 + i]});
            x = x ^ fb[2 + i];
        end
        if (nd < HALF) begin exp_err = 2'd3; return; end
        if (!CK) begin exp_done = 1; return; end
        if (eff == 2 + HALF) exp_err = 2'd3;
        else if (fb[2 + HALF] == x) exp_done = 1;
        else exp_err = 2'd3;
    endtask

    task automatic check_frame(input string tag);
        int matched;
        matched = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] === exp_q[i]) matched++;
        check({tag, ".nwr"}, got_q.size(), exp_q.size());
        check({tag, ".wr_match"}, matched, exp_q.size());
        check({tag, ".err"}, {30'd0, err}, {30'd0, exp_err});
        check({tag, ".done_cnt"}, done_cnt, exp_done);
        if (!CK && exp_done == 1) check({tag, ".done_with_last_wen"}, done_cyc, last_wen_cyc);
    endtask

    task automatic run_frame(input string tag, input byte_q_t fb, input bit collide, input bit gaps);
        frame_start();
        for (int i = 0; i < fb.size(); i++) begin
            send_byte(fb[i], collide && (i == fb.size() - 1));
            if (gaps && $urandom_range(0, 3) == 0) tick();
        end
        frame_end(collide);
        model(fb, collide);
        check_frame(tag);
    endtask

    function automatic byte_q_t load_frame(input logic [7:0] idx, input bit randdata, input int ck_mode);
        byte_q_t q;
        logic [7:0] x;
        logic [7:0] b;
        x = 8'd0;
        q.push_back(8'h01);
        q.push_back(idx);
        for (int i = 0; i < HALF; i++) begin
            b = randdata ? 8'($urandom) : 8'(i);
            q.push_back(b);
            x = x ^ b;
        end
        // ck_mode: 0 = no checksum byte, 1 = correct, 2 = corrupted
        if (ck_mode == 1) q.push_back(x);
        if (ck_mode == 2) q.push_back(x ^ 8'h5A);
        return q;
    endfunction

    initial begin
        byte_q_t fb;
        cs_n     = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        reset_n  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset", {7'd0, w_en, w_select, w_addr, w_data, busy, done, err}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Bytes with chip select high are ignored.
        got_q.delete();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h33, 1'b0);
        tick();
        check("idle.nwr", got_q.size(), 0);
        check("idle.busy", {31'd0, busy}, 32'd0);

        // Full load with incrementing data, back to back.
        fb = load_frame(8'h02, 1'b0, CK ? 1 : 0);
        frame_start();
        check("full.busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < fb.size(); i++) send_byte(fb[i], 1'b0);
        frame_end(1'b0);
        model(fb, 1'b0);
        check_frame("full");

        // Bad opcode.
        fb.delete();
        fb.push_back(8'h7F);
        frame_start();
        send_byte(8'h7F, 1'b0);
        check("badop.busy", {31'd0, busy}, 32'd0);
        check("badop.err_now", {30'd0, err}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            fb.push_back(8'($urandom));
            send_byte(fb[fb.size() - 1], 1'b0);
        end
        frame_end(1'b0);
        model(fb, 1'b0);
        check_frame("badop");

        // Index out of range.
        fb.delete();
        fb.push_back(8'h01);
        fb.push_back(8'h04);
        run_frame("badidx", fb, 1'b0, 1'b0);

        // Abort after 100 data bytes, then err clears on the next frame start.
        fb.delete();
        fb.push_back(8'h01);
        fb.push_back(8'($urandom_range(0, 3)));
        for (int i = 0; i < 100; i++) fb.push_back(8'($urandom));
        run_frame("abort", fb, 1'b0, 1'b1);
        frame_start();
        check("abort.err_clear", {30'd0, err}, 32'd0);
        frame_end(1'b0);

        // Random full loads with idle gaps between bytes.
        for (int k = 0; k < 2; k++) begin
            fb = load_frame(8'($urandom_range(0, 3)), 1'b1, CK ? 1 : 0);
            run_frame("randload", fb, 1'b0, 1'b1);
        end

        if (CK) begin
            fb = load_frame(8'($urandom_range(0, 3)), 1'b1, 2);
            run_frame("badck", fb, 1'b0, 1'b0);
        end

        // Last data byte coincides with chip-select release.
        fb = load_frame(8'd1, 1'b1, 0);
        run_frame("collide", fb, 1'b1, 1'b0);

        // Short random frames: mixed opcodes, indices, lengths and collisions.
        for (int k = 0; k < 8; k++) begin
            fb.delete();
            fb.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h01);
            fb.push_back(8'($urandom_range(0, 5)));
            for (int i = 0; i < int'($urandom_range(0, 30)); i++) fb.push_back(8'($urandom));
            run_frame("short", fb, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
